note_lane_judge: RTL and testbench

- Parametrised note engine for the rhythm game.
- Holds up to DEPTH scrolling notes per lane for LANES lanes and moves them up SPEED pixels every frame.
- Judges keypress edges against the receptor line as perfect, good or miss, and keeps score and combo.
- Sits between the keyboard decoder, the note spawner and the colour mapper, which draws each lane's head note.

---
 rtl/note_lane_judge.sv | 121 ++++++++++++
 tb/tb_note_lane_judge.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/note_lane_judge.sv
// note_lane_judge: per-lane scrolling note queues, receptor-line hit judging, score and combo
module note_lane_judge #(
    parameter int LANES       = 4,
    parameter int DEPTH       = 8,
    parameter int Y_W         = 10,
    parameter int SPEED       = 2,
    parameter int SPAWN_Y     = 479,
    parameter int RECEPTOR_Y  = 40,
    parameter int PERFECT_WIN = 4,
    parameter int GOOD_WIN    = 12
) (
    input  logic                     Clk,
    input  logic                     reset,
    input  logic                     frame_tick,
    input  logic                     spawn_valid,
    input  logic [$clog2(LANES)-1:0] spawn_lane,
    output logic                     spawn_ready,
    input  logic [LANES-1:0]         press,
    output logic [LANES-1:0]         head_valid,
    output logic [LANES*Y_W-1:0]     head_y,
    output logic                     judge_valid,
    output logic [$clog2(LANES)-1:0] judge_lane,
    output logic [1:0]               judge_grade,
    output logic [15:0]              score,
    output logic [7:0]               combo
);
    localparam int LW = $clog2(LANES);
    localparam int PW = $clog2(DEPTH);
    localparam logic [Y_W-1:0] SP = Y_W'(SPEED);
    localparam logic [Y_W-1:0] SY = Y_W'(SPAWN_Y);
    localparam logic [Y_W:0] RY = (Y_W+1)'(RECEPTOR_Y);
    localparam logic [Y_W:0] PWIN = (Y_W+1)'(PERFECT_WIN);
    localparam logic [Y_W:0] GWIN = (Y_W+1)'(GOOD_WIN);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [Y_W-1:0] mem [LANES][DEPTH];
    logic [PW-1:0] rd [LANES];
    logic [PW-1:0] wr [LANES];
    logic [PW:0] cnt [LANES];
    logic [LANES-1:0] press_q, press_pend, miss_pend;
    logic [Y_W-1:0] head [LANES];
    logic [Y_W-1:0] head_mv [LANES];
    logic [LANES-1:0] push, miss_pop, hit_pop, pick, clr;
    logic [LW-1:0] sel;
    logic [Y_W:0] hy, d;
    logic sel_miss, arb, hit, judge;
    logic [1:0] grade;
    logic [16:0] score_sum;

    always_comb begin
        spawn_ready = cnt[spawn_lane] != FULL;
        for (int l = 0; l < LANES; l++) begin
            head[l] = mem[l][rd[l]];
            head_mv[l] = head[l] >= SP ? head[l] - SP : '0;
            head_valid[l] = cnt[l] != '0;
            head_y[l*Y_W +: Y_W] = cnt[l] != '0 ? head[l] : '0;
            push[l] = spawn_valid && cnt[l] != FULL && spawn_lane == LW'(l);
            // one bit wider so y+GOOD_WIN cannot wrap
            miss_pop[l] = frame_tick && cnt[l] != '0 && ({1'b0, head_mv[l]} + GWIN < RY);
        end
        sel_miss = |miss_pend;
        pick = sel_miss ? miss_pend : press_pend;
        sel = '0;
        for (int l = LANES-1; l >= 0; l--)
            if (pick[l]) sel = LW'(l);
        arb = !frame_tick && |pick;
        hy = {1'b0, head[sel]};
        d = hy >= RY ? hy - RY : RY - hy;
        hit = arb && !sel_miss && cnt[sel] != '0 && d <= GWIN;
        judge = arb && (sel_miss || hit);
        grade = sel_miss ? 2'd0 : d <= PWIN ? 2'd2 : 2'd1;
        clr = arb ? LANES'(1) << sel : '0;
        hit_pop = hit ? clr : '0;
        score_sum = {1'b0, score} + 17'(grade);
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            for (int l = 0; l < LANES; l++) begin
                rd[l] <= '0;
                wr[l] <= '0;
                cnt[l] <= '0;
            end
            press_q <= '0;
            press_pend <= '0;
            miss_pend <= '0;
            judge_valid <= 1'b0;
            judge_lane <= '0;
            judge_grade <= '0;
            score <= '0;
            combo <= '0;
        end else begin
            for (int l = 0; l < LANES; l++) begin
                if (frame_tick)
                    for (int s = 0; s < DEPTH; s++)
                        mem[l][s] <= mem[l][s] >= SP ? mem[l][s] - SP : '0;
                // written after the move so a fresh note starts at SPAWN_Y
                if (push[l]) begin
                    mem[l][wr[l]] <= SY;
                    wr[l] <= wr[l] + PW'(1);
                end
                if (miss_pop[l] || hit_pop[l]) rd[l] <= rd[l] + PW'(1);
                cnt[l] <= cnt[l] + (PW+1)'(push[l]) - (PW+1)'(miss_pop[l] || hit_pop[l]);
            end
            press_q <= press;
            press_pend <= (press_pend & ~(clr & {LANES{!sel_miss}})) | (press & ~press_q);
            miss_pend <= (miss_pend & ~(clr & {LANES{sel_miss}})) | miss_pop;
            judge_valid <= judge;
            judge_lane <= sel;
            judge_grade <= grade;
            if (judge) begin
                if (sel_miss) begin
                    combo <= '0;
                end else begin
                    score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    combo <= combo == 8'hFF ? combo : combo + 8'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_note_lane_judge.sv
// tb_note_lane_judge: directed scenarios plus random traffic against a queue-based model
module tb_note_lane_judge;
    localparam int LANES = 4, DEPTH = 8, Y_W = 10;
    localparam int SPEED = 2, SPAWN_Y = 479, RY = 40, PWIN = 4, GWIN = 12;

    logic Clk = 1'b0, reset = 1'b0, frame_tick = 1'b0, spawn_valid = 1'b0;
    logic [1:0] spawn_lane = 2'd0;
    logic spawn_ready;
    logic [3:0] press = 4'd0;
    logic [3:0] head_valid;
    logic [39:0] head_y;
    logic judge_valid;
    logic [1:0] judge_lane, judge_grade;
    logic [15:0] score;
    logic [7:0] combo;

    int n_chk = 0, n_fail = 0;
    int mq [LANES][$];
    logic [3:0] mpq = 4'd0, mpp = 4'd0, mmp = 4'd0;
    bit mjv = 1'b0;
    int mjl = 0, mjg = 0, mscore = 0, mcombo = 0;

    note_lane_judge dut (
        .Clk(Clk), .reset(reset), .frame_tick(frame_tick), .spawn_valid(spawn_valid),
        .spawn_lane(spawn_lane), .spawn_ready(spawn_ready), .press(press),
        .head_valid(head_valid), .head_y(head_y), .judge_valid(judge_valid),
        .judge_lane(judge_lane), .judge_grade(judge_grade), .score(score), .combo(combo)
    );

    always #5 Clk = ~Clk;

    function automatic int hy(input int l);
        return int'(head_y[l*Y_W +: Y_W]);
    endfunction

    // applies one cycle of inputs and advances the reference model by the same cycle
    task automatic drive(input bit r, input bit t, input bit sv, input logic [1:0] sl, input logic [3:0] pr);
        int sel, y, d;
        bit ready;
        reset = r; frame_tick = t; spawn_valid = sv; spawn_lane = sl; press = pr;
        ready = mq[sl].size() < DEPTH;
        if (r) begin
            for (int l = 0; l < LANES; l++) mq[l].delete();
            mpq = 4'd0; mpp = 4'd0; mmp = 4'd0; mjv = 1'b0; mscore = 0; mcombo = 0;
        end else begin
            mjv = 1'b0;
            sel = -1;
            if (!t) begin
                for (int l = LANES-1; l >= 0; l--) if (mmp[l]) sel = l;
                if (sel >= 0) begin
                    mmp[sel] = 1'b0; mjv = 1'b1; mjl = sel; mjg = 0; mcombo = 0;
                end else begin
                    for (int l = LANES-1; l >= 0; l--) if (mpp[l]) sel = l;
                    if (sel >= 0) begin
                        mpp[sel] = 1'b0;
                        if (mq[sel].size() > 0) begin
                            y = mq[sel][0];
                            d = y > RY ? y - RY : RY - y;
                            if (d <= GWIN) begin
                                void'(mq[sel].pop_front());
                                mjv = 1'b1; mjl = sel; mjg = d <= PWIN ? 2 : 1;
                                mscore = mscore + mjg > 65535 ? 65535 : mscore + mjg;
                                mcombo = mcombo == 255 ? 255 : mcombo + 1;
                            end
                        end
                    end
                end
            end else begin
                for (int l = 0; l < LANES; l++) begin
                    for (int i = 0; i < mq[l].size(); i++)
                        mq[l][i] = mq[l][i] > SPEED ? mq[l][i] - SPEED : 0;
                    if (mq[l].size() > 0 && mq[l][0] + GWIN < RY) begin
                        void'(mq[l].pop_front());
                        mmp[l] = 1'b1;
                    end
                end
            end
            if (sv && ready) mq[sl].push_back(SPAWN_Y);
            mpp = mpp | (pr & ~mpq);
            mpq = pr;
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(); drive(1'b0, 1'b0, 1'b0, 2'd0, 4'd0); endtask
    task automatic rst(); drive(1'b1, 1'b0, 1'b0, 2'd0, 4'd0); endtask
    task automatic push(input logic [1:0] l); drive(1'b0, 1'b0, 1'b1, l, 4'd0); endtask
    task automatic prs(input logic [3:0] p); drive(1'b0, 1'b0, 1'b0, 2'd0, p); endtask
    task automatic tick1(); drive(1'b0, 1'b1, 1'b0, 2'd0, 4'd0); endtask
    task automatic ticks(input int n);
        repeat (n) begin tick1(); idle(); end
    endtask

    task automatic test_reset();
        press = 4'b0000;
        rst();
        n_chk++; if (head_valid !== 4'd0 || head_y !== 40'd0) begin n_fail++; $display("FAIL reset_heads: got valid=%b y=%h want 0 0", head_valid, head_y); end
        n_chk++; if (judge_valid !== 1'b0 || judge_lane !== 2'd0 || judge_grade !== 2'd0) begin n_fail++; $display("FAIL reset_judge: got v=%b lane=%0d grade=%0d want 0 0 0", judge_valid, judge_lane, judge_grade); end
        n_chk++; if (score !== 16'd0 || combo !== 8'd0) begin n_fail++; $display("FAIL reset_score: got score=%0d combo=%0d want 0 0", score, combo); end
        n_chk++; if (spawn_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", spawn_ready); end
    endtask

    task automatic test_perfect();
        rst();
        repeat (4) idle();
        push(2'd1);
        ticks(219);
        n_chk++; if (head_valid[1] !== 1'b1 || hy(1) !== 41) begin n_fail++; $display("FAIL perfect_pos: got valid=%b y=%0d want 1 41", head_valid[1], hy(1)); end
        prs(4'b0010);
        n_chk++; if (judge_valid !== 1'b0) begin n_fail++; $display("FAIL perfect_early: got v=%b want 0", judge_valid); end
        idle();
        n_chk++; if (judge_valid !== 1'b1 || judge_lane !== 2'd1 || judge_grade !== 2'd2) begin n_fail++; $display("FAIL perfect_judge: got v=%b lane=%0d grade=%0d want 1 1 2", judge_valid, judge_lane, judge_grade); end
        n_chk++; if (score !== 16'd2 || combo !== 8'd1 || head_valid[1] !== 1'b0) begin n_fail++; $display("FAIL perfect_score: got score=%0d combo=%0d valid=%b want 2 1 0", score, combo, head_valid[1]); end
        idle();
        n_chk++; if (judge_valid !== 1'b0) begin n_fail++; $display("FAIL perfect_pulse: got v=%b want 0", judge_valid); end
    endtask

    task automatic test_good_window();
        rst();
        push(2'd0);
        ticks(214);
        n_chk++; if (hy(0) !== 51) begin n_fail++; $display("FAIL good_pos: got %0d want 51", hy(0)); end
        prs(4'b0001);
        idle();
        n_chk++; if (judge_valid !== 1'b1 || judge_lane !== 2'd0 || judge_grade !== 2'd1 || score !== 16'd1 || combo !== 8'd1) begin n_fail++; $display("FAIL good_judge: got v=%b lane=%0d grade=%0d score=%0d combo=%0d want 1 0 1 1 1", judge_valid, judge_lane, judge_grade, score, combo); end
        push(2'd0);
        ticks(211);
        prs(4'b0001);
        repeat (3) begin
            idle();
            n_chk++; if (judge_valid !== 1'b0) begin n_fail++; $display("FAIL outside_judge: got v=%b want 0", judge_valid); end
        end
        n_chk++; if (head_valid[0] !== 1'b1 || hy(0) !== 57 || score !== 16'd1) begin n_fail++; $display("FAIL outside_head: got valid=%b y=%0d score=%0d want 1 57 1", head_valid[0], hy(0), score); end
    endtask

    task automatic test_miss();
        rst();
        repeat (5) push(2'd0);
        push(2'd3);
        ticks(219);
        repeat (5) begin
            prs(4'b0001);
            idle();
            n_chk++; if (judge_valid !== 1'b1 || judge_grade !== 2'd2) begin n_fail++; $display("FAIL miss_setup: got v=%b grade=%0d want 1 2", judge_valid, judge_grade); end
        end
        n_chk++; if (combo !== 8'd5 || score !== 16'd10) begin n_fail++; $display("FAIL miss_combo5: got combo=%0d score=%0d want 5 10", combo, score); end
        ticks(6);
        n_chk++; if (head_valid[3] !== 1'b1 || hy(3) !== 29) begin n_fail++; $display("FAIL miss_pre: got valid=%b y=%0d want 1 29", head_valid[3], hy(3)); end
        tick1();
        n_chk++; if (head_valid[3] !== 1'b0 || judge_valid !== 1'b0) begin n_fail++; $display("FAIL miss_pop: got valid=%b v=%b want 0 0", head_valid[3], judge_valid); end
        idle();
        n_chk++; if (judge_valid !== 1'b1 || judge_lane !== 2'd3 || judge_grade !== 2'd0) begin n_fail++; $display("FAIL miss_judge: got v=%b lane=%0d grade=%0d want 1 3 0", judge_valid, judge_lane, judge_grade); end
        n_chk++; if (combo !== 8'd0 || score !== 16'd10) begin n_fail++; $display("FAIL miss_score: got combo=%0d score=%0d want 0 10", combo, score); end
    endtask

    task automatic test_reset_mid();
        push(2'd0); push(2'd1); push(2'd2);
        prs(4'b0010);
        rst();
        n_chk++; if (head_valid !== 4'd0 || head_y !== 40'd0 || score !== 16'd0 || combo !== 8'd0 || judge_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_state: got valid=%b score=%0d combo=%0d v=%b want 0 0 0 0", head_valid, score, combo, judge_valid); end
        repeat (4) begin
            idle();
            n_chk++; if (judge_valid !== 1'b0 || head_valid !== 4'd0) begin n_fail++; $display("FAIL midreset_quiet: got v=%b valid=%b want 0 0", judge_valid, head_valid); end
        end
    endtask

    task automatic test_full();
        rst();
        repeat (8) push(2'd2);
        n_chk++; if (spawn_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", spawn_ready); end
        push(2'd2);
        n_chk++; if (spawn_ready !== 1'b0) begin n_fail++; $display("FAIL full_drop_ready: got %b want 0", spawn_ready); end
        ticks(219);
        prs(4'b0100);
        idle();
        n_chk++; if (judge_valid !== 1'b1 || judge_lane !== 2'd2 || judge_grade !== 2'd2) begin n_fail++; $display("FAIL full_pop: got v=%b lane=%0d grade=%0d want 1 2 2", judge_valid, judge_lane, judge_grade); end
        spawn_lane = 2'd2;
        #1;
        n_chk++; if (spawn_ready !== 1'b1) begin n_fail++; $display("FAIL full_after_pop: got %b want 1", spawn_ready); end
        repeat (7) begin
            prs(4'b0100);
            idle();
            n_chk++; if (judge_valid !== 1'b1) begin n_fail++; $display("FAIL full_drain: got v=%b want 1", judge_valid); end
        end
        prs(4'b0100);
        idle();
        n_chk++; if (judge_valid !== 1'b0 || head_valid[2] !== 1'b0 || combo !== 8'd8) begin n_fail++; $display("FAIL full_count: got v=%b valid=%b combo=%0d want 0 0 8", judge_valid, head_valid[2], combo); end
    endtask

    task automatic test_back_to_back();
        rst();
        push(2'd0);
        push(2'd3);
        ticks(219);
        prs(4'b1001);
        n_chk++; if (judge_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_early: got v=%b want 0", judge_valid); end
        idle();
        n_chk++; if (judge_valid !== 1'b1 || judge_lane !== 2'd0 || judge_grade !== 2'd2) begin n_fail++; $display("FAIL b2b_first: got v=%b lane=%0d grade=%0d want 1 0 2", judge_valid, judge_lane, judge_grade); end
        idle();
        n_chk++; if (judge_valid !== 1'b1 || judge_lane !== 2'd3 || judge_grade !== 2'd2) begin n_fail++; $display("FAIL b2b_second: got v=%b lane=%0d grade=%0d want 1 3 2", judge_valid, judge_lane, judge_grade); end
        n_chk++; if (combo !== 8'd2 || score !== 16'd4) begin n_fail++; $display("FAIL b2b_score: got combo=%0d score=%0d want 2 4", combo, score); end
    endtask

    task automatic test_random();
        logic [3:0] pr;
        int ey;
        pr = 4'd0;
        rst();
        for (int c = 0; c < 5000; c++) begin
            if ($urandom_range(0, 3) == 0) pr = pr ^ 4'($urandom_range(1, 15));
            drive($urandom_range(0, 2499) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)), pr);
            for (int l = 0; l < LANES; l++) begin
                ey = mq[l].size() > 0 ? mq[l][0] : 0;
                n_chk++; if (head_valid[l] !== (mq[l].size() > 0) || hy(l) !== ey) begin n_fail++; $display("FAIL rand_head%0d cyc %0d: got valid=%b y=%0d want %b %0d", l, c, head_valid[l], hy(l), mq[l].size() > 0, ey); end
            end
            n_chk++; if (judge_valid !== mjv || (mjv && (int'(judge_lane) !== mjl || int'(judge_grade) !== mjg))) begin n_fail++; $display("FAIL rand_judge cyc %0d: got v=%b lane=%0d grade=%0d want %b %0d %0d", c, judge_valid, judge_lane, judge_grade, mjv, mjl, mjg); end
            n_chk++; if (int'(score) !== mscore || int'(combo) !== mcombo) begin n_fail++; $display("FAIL rand_score cyc %0d: got score=%0d combo=%0d want %0d %0d", c, score, combo, mscore, mcombo); end
            n_chk++; if (spawn_ready !== (mq[spawn_lane].size() < DEPTH)) begin n_fail++; $display("FAIL rand_ready cyc %0d: got %b want %b", c, spawn_ready, mq[spawn_lane].size() < DEPTH); end
        end
    endtask

    initial begin
        test_reset();
        test_perfect();
        test_good_window();
        test_miss();
        test_reset_mid();
        test_full();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
